// File: rtl/s4_actividad2_pkg.sv
// Shared types for the s4_actividad2 up/down counter slice.
// Holds the default width and the next-state operation selector.
`timescale 1ns/1ps
package s4_actividad2_pkg;

   localparam int S4_DEFAULT_N = 4;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_UP,
      OP_DOWN,
      OP_LOAD,
      OP_CLEAR
   } cnt_op_e;

   // Encodes reset > load > enable > hold priority in one place
   function automatic cnt_op_e sel_op(
      input logic reset,
      input logic load,
      input logic enable,
      input logic dec
   );
      if (reset)       return OP_CLEAR;
      else if (load)   return OP_LOAD;
      else if (enable) return dec ? OP_DOWN : OP_UP;
      else             return OP_HOLD;
   endfunction

endpackage

// File: rtl/s4_threshold_cmp.sv
// Unsigned greater-or-equal comparator feeding the threshold flag.
// Purely combinational so the flag tracks the reference immediately.
`timescale 1ns/1ps
module s4_threshold_cmp #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ge
);

   assign ge = (a >= b);

endmodule

// File: rtl/s4_actividad2.sv
// N-bit up/down counter with parallel load and a >= threshold flag.
// Synchronous active-high reset; all arithmetic wraps modulo 2^N.
`timescale 1ns/1ps
module s4_actividad2
   import s4_actividad2_pkg::*;
#(
   parameter int N = S4_DEFAULT_N
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         dec,
   input  logic         load,
   input  logic [N-1:0] Load_Ref_value,
   output logic [N-1:0] counterN,
   output logic         threshold
);

   logic [N-1:0] cnt_q;
   logic [N-1:0] cnt_next;
   cnt_op_e      op;

   assign op = sel_op(reset, load, enable, dec);

   always_comb begin
      cnt_next = cnt_q;
      unique case (op)
         OP_CLEAR: cnt_next = '0;
         OP_LOAD:  cnt_next = Load_Ref_value;
         OP_UP:    cnt_next = cnt_q + 1'b1;
         OP_DOWN:  cnt_next = cnt_q - 1'b1;
         default:  cnt_next = cnt_q;
      endcase
   end

   always_ff @(posedge clock) begin
      cnt_q <= cnt_next;
   end

   assign counterN = cnt_q;

   s4_threshold_cmp #(
      .N(N)
   ) u_cmp (
      .a  (cnt_q),
      .b  (Load_Ref_value),
      .ge (threshold)
   );

endmodule

// File: tb/tb_s4_actividad2.sv
// Self-checking bench for s4_actividad2: directed vector table,
// hand-written threshold sequence, and randomized model comparison.
`timescale 1ns/1ps
module tb_s4_actividad2;

   localparam int N = 4;
   localparam int MOD = 1 << N;

   typedef struct {
      logic         rst;
      logic         ld;
      logic         en;
      logic         dn;
      logic [N-1:0] ref_v;
      logic [N-1:0] exp_cnt;
      logic         exp_thr;
   } vec_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         dec = 1'b0;
   logic         load = 1'b0;
   logic [N-1:0] Load_Ref_value = '0;
   logic [N-1:0] counterN;
   logic         threshold;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   s4_actividad2 #(
      .N(N)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .dec            (dec),
      .load           (load),
      .Load_Ref_value (Load_Ref_value),
      .counterN       (counterN),
      .threshold      (threshold)
   );

   always #1 clock = ~clock;

   task automatic chk_cnt(input string name, input logic [N-1:0] exp);
      checks++;
      if (counterN !== exp) begin
         errors++;
         $display("FAIL %s: counterN=%0h expected %0h at %0t",
                  name, counterN, exp, $time);
      end
   endtask

   task automatic chk_thr(input string name, input logic exp);
      checks++;
      if (threshold !== exp) begin
         errors++;
         $display("FAIL %s: threshold=%0b expected %0b at %0t",
                  name, threshold, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic l, input logic e,
                        input logic d, input logic [N-1:0] rv);
      reset = r;
      load = l;
      enable = e;
      dec = d;
      Load_Ref_value = rv;
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic vec_t mk(input logic r, input logic l,
                               input logic e, input logic d,
                               input int rv, input int ec,
                               input logic et);
      vec_t v;
      v.rst = r;
      v.ld = l;
      v.en = e;
      v.dn = d;
      v.ref_v = N'(rv);
      v.exp_cnt = N'(ec);
      v.exp_thr = et;
      return v;
   endfunction

   int m;
   logic exp_t;

   initial begin
      // 1: reset then idle
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 0, 0, 15, 0, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, i[0], 15, 0, 0));
      // 2: count up with wrap
      for (int i = 1; i <= 17; i++)
         vecs.push_back(mk(0, 0, 1, 0, 15, i % MOD, (i % MOD) == 15));
      // 3: count down from 0
      vecs.push_back(mk(1, 0, 0, 0, 15, 0, 0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(0, 0, 1, 1, 15, (MOD - i) % MOD,
                           ((MOD - i) % MOD) == 15));
      // 4: load wins over enable/dec
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(1, 0, 0, 0, 15, 0, 0));
         vecs.push_back(mk(0, 1, i[0], i[1], 15, 15, 1));
      end
      vecs.push_back(mk(0, 1, 1, 0, 8, 8, 1));
      // 5: reset wins over everything
      vecs.push_back(mk(1, 1, 1, 0, 8, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 8, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1));

      @(negedge clock);
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].dn,
               vecs[i].ref_v);
         chk_cnt($sformatf("vec%0d_cnt", i), vecs[i].exp_cnt);
         chk_thr($sformatf("vec%0d_thr", i), vecs[i].exp_thr);
      end

      // 6: combinational threshold follows reference
      drive(0, 1, 0, 0, 4'd5);
      chk_cnt("seq6_load", 4'd5);
      reset = 0;
      load = 0;
      enable = 0;
      Load_Ref_value = 4'd3;
      #0.2;
      chk_thr("seq6_ref3", 1'b1);
      Load_Ref_value = 4'd5;
      #0.2;
      chk_thr("seq6_ref5", 1'b1);
      Load_Ref_value = 4'd9;
      #0.2;
      chk_thr("seq6_ref9", 1'b0);
      @(negedge clock);
      chk_cnt("seq6_hold", 4'd5);
      chk_thr("seq6_hold_thr", 1'b0);

      // Randomized run against arithmetic reference model
      drive(1, 0, 0, 0, 4'd0);
      m = 0;
      chk_cnt("rnd_reset", 4'd0);
      for (int k = 0; k < 400; k++) begin
         logic r, l, e, d;
         logic [N-1:0] rv;
         r = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 7) == 0);
         e = ($urandom_range(0, 3) != 0);
         d = $urandom_range(0, 1) == 1;
         rv = N'($urandom_range(0, MOD - 1));
         if (r)      m = 0;
         else if (l) m = int'(rv);
         else if (e) m = d ? (m + MOD - 1) % MOD : (m + 1) % MOD;
         drive(r, l, e, d, rv);
         exp_t = (m >= int'(rv));
         chk_cnt($sformatf("rnd%0d_cnt", k), N'(m));
         chk_thr($sformatf("rnd%0d_thr", k), exp_t);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
